prog_lut_engine: RTL and testbench



---
 rtl/prog_lut_engine.sv | 109 ++++++++++
 tb/tb_prog_lut_engine.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/prog_lut_engine.sv
// prog_lut_engine: run-time programmable truth table.
// After reset, an init FSM fills every entry with DEFAULT_OUT. In RUN, the
// table is written through wr_* and read through a valid/ready lookup port
// with one cycle of registered latency.
module prog_lut_engine #(
    parameter int                 IN_W        = 5,
    parameter int                 OUT_W       = 2,
    parameter logic [OUT_W-1:0]   DEFAULT_OUT = {OUT_W{1'b1}},
    parameter int                 CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IN_W-1:0]  wr_addr,
    input  logic [OUT_W-1:0] wr_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             busy,
    output logic [CNT_W-1:0] lookup_cnt
);

    localparam int DEPTH = 1 << IN_W;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [IN_W-1:0]   init_ptr;
    logic [OUT_W-1:0]  table_mem [DEPTH];
    logic              accept;
    logic [OUT_W-1:0]  lookup_val;

    // State register; reset always restarts the fill.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of block ordering.
        if (rst) begin
            state <= ST_INIT;
        end else begin
            state <= state_next;
        end
    end

    // Next state: leave INIT once the last entry has been written.
    always_comb begin
        // NOTE: defaulting every always_comb output first prevents latches.
        state_next = state;
        if (state == ST_INIT && init_ptr == {IN_W{1'b1}}) begin
            state_next = ST_RUN;
        end
    end

    // Init fill pointer walks 0 .. DEPTH-1 while in INIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            init_ptr <= '0;
        end else if (state == ST_INIT) begin
            init_ptr <= init_ptr + IN_W'(1);
        end
    end

    // Table storage: filled by init, then by the write port in RUN.
    always_ff @(posedge clk) begin
        // NOTE: the table has no reset branch; the init FSM overwrites every
        // entry, which keeps it mappable onto plain RAM.
        if (!rst) begin
            if (state == ST_INIT) begin
                table_mem[init_ptr] <= DEFAULT_OUT;
            end else if (wr_en) begin
                table_mem[wr_addr] <= wr_data;
            end
        end
    end

    assign busy     = (state == ST_INIT);
    assign in_ready = (state == ST_RUN) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Write-first bypass: a same-cycle write to the looked-up entry wins.
    always_comb begin
        lookup_val = table_mem[in_code];
        if (wr_en && wr_addr == in_code) begin
            lookup_val = wr_data;
        end
    end

    // Result register, valid flag and lookup counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            lookup_cnt <= '0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_data   <= lookup_val;
            lookup_cnt <= lookup_cnt + CNT_W'(1);
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_prog_lut_engine.sv
// Self-checking bench for prog_lut_engine: directed test-plan sequences plus
// randomized traffic, compared each cycle against a behavioural model.
module tb_prog_lut_engine;

    localparam int IN_W  = 5;
    localparam int OUT_W = 2;
    localparam int CNT_W = 8;
    localparam int DEPTH = 1 << IN_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_en;
    logic [IN_W-1:0]  wr_addr;
    logic [OUT_W-1:0] wr_data;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_code;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             busy;
    logic [CNT_W-1:0] lookup_cnt;

    prog_lut_engine #(
        .IN_W(IN_W), .OUT_W(OUT_W), .DEFAULT_OUT(2'b11), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .in_valid(in_valid), .in_ready(in_ready),
        .in_code(in_code), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy), .lookup_cnt(lookup_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    // Behavioural model: init countdown, table contents, result register.
    bit  m_known    = 0;
    int  m_init_left;
    int  m_tbl [DEPTH];
    bit  m_valid;
    int  m_data;
    int  m_cnt;
    int  busy_run;       // consecutive busy cycles observed after rst fell

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check combinational outputs, advance model,
    // check registered outputs.
    task automatic step(input bit r, input bit we, input int wa, input int wd,
                        input bit iv, input int ic, input bit ordy);
        bit exp_ready;
        bit acc;
        @(negedge clk);
        rst = r; wr_en = we; wr_addr = IN_W'(wa); wr_data = OUT_W'(wd);
        in_valid = iv; in_code = IN_W'(ic); out_ready = ordy;
        #1;
        exp_ready = (m_init_left == 0) && (!m_valid || ordy);
        if (m_known) begin
            check("in_ready", 32'(in_ready), 32'(exp_ready));
            check("busy", 32'(busy), 32'(m_init_left != 0));
        end
        @(posedge clk);
        if (r) begin
            m_known = 1; m_init_left = DEPTH; m_valid = 0; m_data = 0; m_cnt = 0;
        end else if (m_init_left != 0) begin
            m_init_left--;
            if (m_init_left == 0) foreach (m_tbl[i]) m_tbl[i] = 3;
        end else begin
            acc = iv && exp_ready;
            if (acc) begin
                m_data  = (we && wa == ic) ? wd : m_tbl[ic];
                m_valid = 1;
                m_cnt   = (m_cnt + 1) % (1 << CNT_W);
            end else if (ordy) begin
                m_valid = 0;
            end
            if (we) m_tbl[wa] = wd;
        end
        #1;
        if (m_known) begin
            check("out_valid", 32'(out_valid), 32'(m_valid));
            check("out_data", 32'(out_data), 32'(m_data));
            check("lookup_cnt", 32'(lookup_cnt), 32'(m_cnt));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 1);
    endtask

    // Counts busy cycles after rst falls until it drops; bounded.
    task automatic reset_and_measure(input string tag, input bit pulse_wr);
        int cycles;
        step(1, 0, 0, 0, 0, 0, 1);
        cycles = 0;
        while (busy === 1'b1 && cycles < 3 * DEPTH) begin
            step(0, pulse_wr, cycles % DEPTH, 0, 1, 0, 1);
            cycles++;
        end
        busy_run = cycles;
        check(tag, 32'(busy_run), 32'(DEPTH));
    endtask

    initial begin
        rst = 1; wr_en = 0; wr_addr = '0; wr_data = '0;
        in_valid = 0; in_code = '0; out_ready = 1;

        // Reset then idle: busy for exactly DEPTH cycles, defaults read back.
        step(1, 0, 0, 0, 0, 0, 1);
        check("rst_out_data", 32'(out_data), 32'(0));
        reset_and_measure("init_len", 0);
        step(0, 0, 0, 0, 1, 0, 1);
        check("dflt_0", 32'(out_data), 32'(2'b11));
        step(0, 0, 0, 0, 1, 13, 1);
        check("dflt_13", 32'(out_data), 32'(2'b11));
        step(0, 0, 0, 0, 1, 31, 1);
        check("dflt_31", 32'(out_data), 32'(2'b11));
        idle(1);

        // Write then read back; neighbour still default.
        step(0, 1, 5'b11000, 2'b00, 0, 0, 1);
        step(0, 0, 0, 0, 1, 5'b11000, 1);
        check("wr_rd_24", 32'(out_data), 32'(2'b00));
        step(0, 0, 0, 0, 1, 5'b11001, 1);
        check("wr_rd_25", 32'(out_data), 32'(2'b11));

        // Same-cycle write/lookup bypass.
        step(0, 1, 5'b00010, 2'b10, 1, 5'b00010, 1);
        check("bypass", 32'(out_data), 32'(2'b10));
        idle(1);

        // Eight back-to-back lookups.
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1, 22 + i, 1);
        idle(1);

        // Stall for 3 cycles with a request pending, then release.
        step(0, 1, 7, 1, 1, 7, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 1, 2, 0);
            check("stall_hold", 32'(out_data), 32'(2'b01));
        end
        step(0, 0, 0, 0, 1, 2, 1);
        step(0, 0, 0, 0, 1, 24, 1);
        idle(2);

        // Reset mid-stream with wr_en pulses during INIT.
        step(0, 0, 0, 0, 1, 7, 0);
        reset_and_measure("reinit_len", 1);
        step(0, 0, 0, 0, 1, 5'b11000, 1);
        check("reinit_24", 32'(out_data), 32'(2'b11));
        step(0, 0, 0, 0, 1, 5'b00010, 1);
        check("reinit_2", 32'(out_data), 32'(2'b11));

        // Randomized traffic, occasional reset; long enough to wrap lookup_cnt.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 499) == 0), ($urandom_range(0, 3) == 0),
                 $urandom_range(0, DEPTH - 1), $urandom_range(0, 3),
                 ($urandom_range(0, 3) != 0), $urandom_range(0, DEPTH - 1),
                 ($urandom_range(0, 3) != 0));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
